// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared types and helpers for the drive scheduler:
//   - motion command codes issued by the command sources
//   - per-wheel direction request and wheel controller state encodings
//   - grant encoding used by the priority arbiter
//   - ramp_step(): one saturating ramp step of the current speed toward a goal
// -----------------------------------------------------------------------------
package drive_pkg;

  typedef enum logic [2:0] {
    CMD_STOP   = 3'd0,
    CMD_FWD    = 3'd1,
    CMD_BACK   = 3'd2,
    CMD_LEFT   = 3'd3,
    CMD_RIGHT  = 3'd4,
    CMD_SPIN_L = 3'd5,
    CMD_SPIN_R = 3'd6,
    CMD_RSVD   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DECEL = 2'd2,
    ST_DEAD  = 2'd3
  } wheel_state_e;

  localparam logic [1:0] GRANT_OBS  = 2'd0;
  localparam logic [1:0] GRANT_BT   = 2'd1;
  localparam logic [1:0] GRANT_AU   = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  // Move cur toward goal by step. The sum is formed in 9 bits so that a large
  // step near 255 cannot wrap; both directions land exactly on goal.
  function automatic logic [7:0] ramp_step(input logic [7:0] cur,
                                           input logic [7:0] goal,
                                           input logic [7:0] step);
    logic [8:0] sum;
    logic [8:0] gap;
    logic [7:0] res;
    sum = {1'b0, cur} + {1'b0, step};
    gap = 9'd0;
    if (cur < goal) begin
      res = (sum > {1'b0, goal}) ? goal : sum[7:0];
    end else if (cur > goal) begin
      gap = {1'b0, cur} - {1'b0, goal};
      res = (gap <= {1'b0, step}) ? goal : (cur - step);
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/wheel_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// wheel_ramp_ctrl
// One wheel's sequencer: IDLE -> RUN -> DECEL -> DEAD, speed ramping on the
// shared tick, and a dead period with both enables low before any reversal.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   estop_i         : forces IDLE with zero speed at the next edge
//   tick_i          : ramp tick shared by both wheels
//   dir_i, target_i : requested direction and target speed
//   en_dir1_o/en_dir2_o/speed_o : registered forward/reverse enables and duty
//   busy_o          : registered, high while the wheel is not IDLE
// -----------------------------------------------------------------------------
module wheel_ramp_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned DEAD_CYC  = 50
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       estop_i,
  input  logic       tick_i,
  input  dir_e       dir_i,
  input  logic [7:0] target_i,
  output logic       en_dir1_o,
  output logic       en_dir2_o,
  output logic [7:0] speed_o,
  output logic       busy_o
);

  localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
  localparam logic [7:0]    STEP8     = 8'(RAMP_STEP);

  wheel_state_e  state_q, state_d;
  dir_e          act_dir_q, act_dir_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    goal_s;
  logic          en1_q, en1_d;
  logic          en2_q, en2_d;
  logic [7:0]    speed_q, speed_d;
  logic          busy_q, busy_d;

  // State register, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      act_dir_q  <= DIR_NONE;
      dead_cnt_q <= '0;
      cur_q      <= 8'd0;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
      speed_q    <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_dir_q  <= act_dir_d;
      dead_cnt_q <= dead_cnt_d;
      cur_q      <= cur_d;
      en1_q      <= en1_d;
      en2_q      <= en2_d;
      speed_q    <= speed_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, dead counter and ramp; the ramp uses the goal of the new state
  always_comb begin
    state_d    = state_q;
    act_dir_d  = act_dir_q;
    dead_cnt_d = dead_cnt_q;
    cur_d      = cur_q;
    goal_s     = 8'd0;
    if (estop_i) begin
      state_d    = ST_IDLE;
      act_dir_d  = DIR_NONE;
      dead_cnt_d = '0;
      cur_d      = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dir_i != DIR_NONE) begin
            state_d   = ST_RUN;
            act_dir_d = dir_i;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (dir_i != act_dir_q) begin
            state_d = ST_DECEL;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DECEL: begin
          if (dir_i == act_dir_q) begin
            state_d = ST_RUN;
          end else if (cur_q == 8'd0) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end else begin
            state_d = ST_DECEL;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q == DEAD_LAST) begin
            dead_cnt_d = '0;
            if (dir_i == DIR_NONE) begin
              state_d   = ST_IDLE;
              act_dir_d = DIR_NONE;
            end else begin
              state_d   = ST_RUN;
              act_dir_d = dir_i;
            end
          end else begin
            dead_cnt_d = dead_cnt_q + DW'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          act_dir_d = DIR_NONE;
        end
      endcase

      goal_s = (state_d == ST_RUN) ? target_i : 8'd0;
      if ((state_d == ST_IDLE) || (state_d == ST_DEAD)) begin
        cur_d = 8'd0;
      end else if (tick_i) begin
        cur_d = ramp_step(cur_q, goal_s, STEP8);
      end else begin
        cur_d = cur_q;
      end
    end
  end

  // Output decode from the next state; only one enable can follow act_dir
  always_comb begin
    en1_d   = 1'b0;
    en2_d   = 1'b0;
    speed_d = cur_d;
    busy_d  = (state_d != ST_IDLE);
    case (state_d)
      ST_RUN, ST_DECEL: begin
        en1_d = (act_dir_d == DIR_FWD);
        en2_d = (act_dir_d == DIR_REV);
      end
      default: begin
        en1_d = 1'b0;
        en2_d = 1'b0;
      end
    endcase
  end

  assign en_dir1_o = en1_q;
  assign en_dir2_o = en2_q;
  assign speed_o   = speed_q;
  assign busy_o    = busy_q;

endmodule

// File: rtl/drive_scheduler.sv
// -----------------------------------------------------------------------------
// drive_scheduler
// Fixed-priority arbiter (obstacle > Bluetooth > auto-seek), command decode to
// per-wheel direction/target, shared ramp tick, and two wheel sequencers.
// Ports:
//   CLK, RST_N                  : clock, asynchronous active-low reset
//   obs_req/obs_cmd/obs_spd     : obstacle source (highest priority)
//   obs_estop                   : level emergency stop, bypasses arbitration
//   bt_req/bt_cmd/bt_spd        : Bluetooth source
//   au_req/au_cmd/au_spd        : auto-seek source (lowest priority)
//   l_en_dir1/l_en_dir2/l_speed : left wheel forward/reverse enable and duty
//   r_en_dir1/r_en_dir2/r_speed : right wheel equivalents
//   grant                       : 0 obs, 1 bt, 2 auto, 3 none
//   busy                        : either wheel not IDLE
// -----------------------------------------------------------------------------
module drive_scheduler
  import drive_pkg::*;
#(
  parameter int unsigned RAMP_DIV  = 1000,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned DEAD_CYC  = 50
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       obs_req,
  input  logic [2:0] obs_cmd,
  input  logic [7:0] obs_spd,
  input  logic       obs_estop,
  input  logic       bt_req,
  input  logic [2:0] bt_cmd,
  input  logic [7:0] bt_spd,
  input  logic       au_req,
  input  logic [2:0] au_cmd,
  input  logic [7:0] au_spd,
  output logic       l_en_dir1,
  output logic       l_en_dir2,
  output logic [7:0] l_speed,
  output logic       r_en_dir1,
  output logic       r_en_dir2,
  output logic [7:0] r_speed,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int unsigned TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);

  logic [1:0]    grant_q, grant_d;
  cmd_e          sel_cmd_q, sel_cmd_d;
  logic [7:0]    sel_spd_q, sel_spd_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_s;
  dir_e          l_dir_s, r_dir_s;
  logic [7:0]    l_tgt_s, r_tgt_s;
  logic          l_busy_s, r_busy_s;

  // Arbiter and ramp-tick registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      grant_q    <= GRANT_NONE;
      sel_cmd_q  <= CMD_STOP;
      sel_spd_q  <= 8'd0;
      tick_cnt_q <= '0;
    end else begin
      grant_q    <= grant_d;
      sel_cmd_q  <= sel_cmd_d;
      sel_spd_q  <= sel_spd_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Fixed-priority selection, re-evaluated every cycle with no lock
  always_comb begin
    grant_d   = GRANT_NONE;
    sel_cmd_d = CMD_STOP;
    sel_spd_d = 8'd0;
    if (obs_req) begin
      grant_d   = GRANT_OBS;
      sel_cmd_d = cmd_e'(obs_cmd);
      sel_spd_d = obs_spd;
    end else if (bt_req) begin
      grant_d   = GRANT_BT;
      sel_cmd_d = cmd_e'(bt_cmd);
      sel_spd_d = bt_spd;
    end else if (au_req) begin
      grant_d   = GRANT_AU;
      sel_cmd_d = cmd_e'(au_cmd);
      sel_spd_d = au_spd;
    end else begin
      grant_d   = GRANT_NONE;
      sel_cmd_d = CMD_STOP;
      sel_spd_d = 8'd0;
    end
  end

  // Free-running tick counter; tick is the terminal count
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Command to per-wheel direction; an idle wheel gets a zero target
  always_comb begin
    l_dir_s = DIR_NONE;
    r_dir_s = DIR_NONE;
    case (sel_cmd_q)
      CMD_STOP:   begin l_dir_s = DIR_NONE; r_dir_s = DIR_NONE; end
      CMD_FWD:    begin l_dir_s = DIR_FWD;  r_dir_s = DIR_FWD;  end
      CMD_BACK:   begin l_dir_s = DIR_REV;  r_dir_s = DIR_REV;  end
      CMD_LEFT:   begin l_dir_s = DIR_NONE; r_dir_s = DIR_FWD;  end
      CMD_RIGHT:  begin l_dir_s = DIR_FWD;  r_dir_s = DIR_NONE; end
      CMD_SPIN_L: begin l_dir_s = DIR_REV;  r_dir_s = DIR_FWD;  end
      CMD_SPIN_R: begin l_dir_s = DIR_FWD;  r_dir_s = DIR_REV;  end
      default:    begin l_dir_s = DIR_NONE; r_dir_s = DIR_NONE; end
    endcase
    l_tgt_s = (l_dir_s != DIR_NONE) ? sel_spd_q : 8'd0;
    r_tgt_s = (r_dir_s != DIR_NONE) ? sel_spd_q : 8'd0;
  end

  wheel_ramp_ctrl #(
    .RAMP_STEP (RAMP_STEP),
    .DEAD_CYC  (DEAD_CYC)
  ) u_left (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .estop_i   (obs_estop),
    .tick_i    (tick_s),
    .dir_i     (l_dir_s),
    .target_i  (l_tgt_s),
    .en_dir1_o (l_en_dir1),
    .en_dir2_o (l_en_dir2),
    .speed_o   (l_speed),
    .busy_o    (l_busy_s)
  );

  wheel_ramp_ctrl #(
    .RAMP_STEP (RAMP_STEP),
    .DEAD_CYC  (DEAD_CYC)
  ) u_right (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .estop_i   (obs_estop),
    .tick_i    (tick_s),
    .dir_i     (r_dir_s),
    .target_i  (r_tgt_s),
    .en_dir1_o (r_en_dir1),
    .en_dir2_o (r_en_dir2),
    .speed_o   (r_speed),
    .busy_o    (r_busy_s)
  );

  assign grant = grant_q;
  assign busy  = l_busy_s | r_busy_s;

endmodule

// File: tb/tb_drive_scheduler.sv
module tb_drive_scheduler;
  import drive_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       obs_req = 1'b0, obs_estop = 1'b0;
  logic [2:0] obs_cmd = 3'd0;
  logic [7:0] obs_spd = 8'd0;
  logic       bt_req = 1'b0;
  logic [2:0] bt_cmd = 3'd0;
  logic [7:0] bt_spd = 8'd0;
  logic       au_req = 1'b0;
  logic [2:0] au_cmd = 3'd0;
  logic [7:0] au_spd = 8'd0;

  logic       l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy;
  logic [7:0] l_speed, r_speed;
  logic [1:0] grant;
  logic       d2_l_en_dir1, d2_l_en_dir2, d2_r_en_dir1, d2_r_en_dir2, d2_busy;
  logic [7:0] d2_l_speed, d2_r_speed;
  logic [1:0] d2_grant;

  int checks = 0;
  int errors = 0;
  int both_on = 0;

  // Scoreboard: index 0 left, 1 right, 2 left wheel of the large-step DUT
  logic [7:0] exp_q[3][$];
  logic [7:0] obs_q[3][$];
  logic [7:0] prev_l = 8'd0, prev_r = 8'd0, prev_d2 = 8'd0;

  always #5 CLK = ~CLK;

  drive_scheduler #(.RAMP_DIV(4), .RAMP_STEP(8), .DEAD_CYC(5)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .obs_req(obs_req), .obs_cmd(obs_cmd), .obs_spd(obs_spd), .obs_estop(obs_estop),
    .bt_req(bt_req), .bt_cmd(bt_cmd), .bt_spd(bt_spd),
    .au_req(au_req), .au_cmd(au_cmd), .au_spd(au_spd),
    .l_en_dir1(l_en_dir1), .l_en_dir2(l_en_dir2), .l_speed(l_speed),
    .r_en_dir1(r_en_dir1), .r_en_dir2(r_en_dir2), .r_speed(r_speed),
    .grant(grant), .busy(busy)
  );

  drive_scheduler #(.RAMP_DIV(4), .RAMP_STEP(200), .DEAD_CYC(5)) dut2 (
    .CLK(CLK), .RST_N(RST_N),
    .obs_req(obs_req), .obs_cmd(obs_cmd), .obs_spd(obs_spd), .obs_estop(obs_estop),
    .bt_req(bt_req), .bt_cmd(bt_cmd), .bt_spd(bt_spd),
    .au_req(au_req), .au_cmd(au_cmd), .au_spd(au_spd),
    .l_en_dir1(d2_l_en_dir1), .l_en_dir2(d2_l_en_dir2), .l_speed(d2_l_speed),
    .r_en_dir1(d2_r_en_dir1), .r_en_dir2(d2_r_en_dir2), .r_speed(d2_r_speed),
    .grant(d2_grant), .busy(d2_busy)
  );

  // Monitor: record every speed change and any cycle with both enables high
  always @(negedge CLK) begin
    if (l_speed !== prev_l) obs_q[0].push_back(l_speed);
    if (r_speed !== prev_r) obs_q[1].push_back(r_speed);
    if (d2_l_speed !== prev_d2) obs_q[2].push_back(d2_l_speed);
    prev_l  <= l_speed;
    prev_r  <= r_speed;
    prev_d2 <= d2_l_speed;
    if ((l_en_dir1 && l_en_dir2) || (r_en_dir1 && r_en_dir2) ||
        (d2_l_en_dir1 && d2_l_en_dir2) || (d2_r_en_dir1 && d2_r_en_dir2))
      both_on <= both_on + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_sb();
    for (int w = 0; w < 3; w++) begin
      exp_q[w].delete();
      obs_q[w].delete();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    obs_req = 1'b1; obs_cmd = CMD_FWD;  obs_spd = 8'd50;
    bt_req  = 1'b1; bt_cmd  = CMD_BACK; bt_spd  = 8'd60;
    au_req  = 1'b1; au_cmd  = CMD_FWD;  au_spd  = 8'd70;
    repeat (3) @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_en got %b expected 00000", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy});
    end
    checks++;
    if ({l_speed, r_speed} !== 16'd0) begin
      errors++; $display("FAIL reset_speed got %0d/%0d expected 0/0", l_speed, r_speed);
    end
    checks++;
    if (grant !== 2'd3) begin errors++; $display("FAIL reset_grant got %0d expected 3", grant); end
    obs_req = 1'b0; bt_req = 1'b0; au_req = 1'b0;
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed} !== 21'd0) begin
      errors++; $display("FAIL post_reset_idle got %b expected 0", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed});
    end
    checks++;
    if (grant !== 2'd3) begin errors++; $display("FAIL post_reset_grant got %0d expected 3", grant); end
  endtask

  task automatic test_ramp_up();
    logic [7:0] e, o;
    @(posedge CLK); #1;
    clear_sb();
    for (int w = 0; w < 2; w++) begin
      exp_q[w].push_back(8'd8); exp_q[w].push_back(8'd16); exp_q[w].push_back(8'd20);
    end
    au_req = 1'b1; au_cmd = CMD_FWD; au_spd = 8'd20;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (grant !== 2'd2) begin errors++; $display("FAIL ramp_grant_n1 got %0d expected 2", grant); end
    checks++;
    if ({l_en_dir1, l_en_dir2} !== 2'b00) begin errors++; $display("FAIL ramp_en_n1 got %b expected 00", {l_en_dir1, l_en_dir2}); end
    @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2} !== 4'b1010) begin
      errors++; $display("FAIL ramp_en_n2 got %b expected 1010", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2});
    end
    repeat (40) @(negedge CLK);
    checks++;
    if ({l_speed, r_speed, busy} !== {8'd20, 8'd20, 1'b1}) begin
      errors++; $display("FAIL ramp_hold got %0d/%0d busy %b expected 20/20 busy 1", l_speed, r_speed, busy);
    end
    for (int w = 0; w < 2; w++) begin
      while (exp_q[w].size() > 0) begin
        e = exp_q[w].pop_front();
        checks++;
        if (obs_q[w].size() == 0) begin errors++; $display("FAIL ramp_seq w%0d got none expected %0d", w, e); end
        else begin
          o = obs_q[w].pop_front();
          if (o !== e) begin errors++; $display("FAIL ramp_seq w%0d got %0d expected %0d", w, o, e); end
        end
      end
      checks++;
      if (obs_q[w].size() != 0) begin errors++; $display("FAIL ramp_seq_extra w%0d got %0d expected 0", w, obs_q[w].size()); end
    end
  endtask

  task automatic test_reversal();
    logic [7:0] e, o;
    int dead_cnt = 0;
    logic found = 1'b0;
    @(posedge CLK); #1;
    clear_sb();
    for (int w = 0; w < 2; w++) begin
      exp_q[w].push_back(8'd12); exp_q[w].push_back(8'd4); exp_q[w].push_back(8'd0);
      exp_q[w].push_back(8'd8);  exp_q[w].push_back(8'd16); exp_q[w].push_back(8'd20);
    end
    au_cmd = CMD_BACK;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if ({l_en_dir1, l_en_dir2} == 2'b00) dead_cnt++;
      if ({l_en_dir1, l_en_dir2} == 2'b01) begin found = 1'b1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL rev_reach got timeout expected en 01"); end
    checks++;
    if (dead_cnt != 5) begin errors++; $display("FAIL rev_dead_len got %0d expected 5", dead_cnt); end
    repeat (40) @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, l_speed, r_speed} !== {4'b0101, 8'd20, 8'd20}) begin
      errors++; $display("FAIL rev_final got %b %0d %0d expected 0101 20 20", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2}, l_speed, r_speed);
    end
    for (int w = 0; w < 2; w++) begin
      while (exp_q[w].size() > 0) begin
        e = exp_q[w].pop_front();
        checks++;
        if (obs_q[w].size() == 0) begin errors++; $display("FAIL rev_seq w%0d got none expected %0d", w, e); end
        else begin
          o = obs_q[w].pop_front();
          if (o !== e) begin errors++; $display("FAIL rev_seq w%0d got %0d expected %0d", w, o, e); end
        end
      end
    end
    checks++;
    if (both_on != 0) begin errors++; $display("FAIL rev_both_en got %0d expected 0", both_on); end
  endtask

  task automatic test_priority();
    logic [7:0] e, o;
    int v;
    logic ok = 1'b0;
    @(posedge CLK); #1 au_cmd = CMD_FWD; au_spd = 8'd100;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2} == 4'b1010 && l_speed == 8'd100 && r_speed == 8'd100) begin ok = 1'b1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL prio_setup got timeout expected fwd 100"); end
    @(posedge CLK); #1;
    clear_sb();
    v = 100;
    while (v > 0) begin v = (v > 8) ? v - 8 : 0; exp_q[0].push_back(8'(v)); end
    while (v < 50) begin v = (v + 8 > 50) ? 50 : v + 8; exp_q[0].push_back(8'(v)); end
    v = 100;
    while (v > 50) begin v = (v - 50 > 8) ? v - 8 : 50; exp_q[1].push_back(8'(v)); end
    bt_req = 1'b1; bt_cmd = CMD_SPIN_L; bt_spd = 8'd50;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (grant !== 2'd1) begin errors++; $display("FAIL prio_grant_bt got %0d expected 1", grant); end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if ({l_en_dir1, l_en_dir2} == 2'b01 && l_speed == 8'd50) begin ok = 1'b1; break; end
    end
    repeat (20) @(negedge CLK);
    checks++;
    if (ok !== 1'b1 || {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, l_speed, r_speed} !== {4'b0110, 8'd50, 8'd50}) begin
      errors++; $display("FAIL prio_spin got %b %0d %0d expected 0110 50 50", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2}, l_speed, r_speed);
    end
    for (int w = 0; w < 2; w++) begin
      while (exp_q[w].size() > 0) begin
        e = exp_q[w].pop_front();
        checks++;
        if (obs_q[w].size() == 0) begin errors++; $display("FAIL prio_seq w%0d got none expected %0d", w, e); end
        else begin
          o = obs_q[w].pop_front();
          if (o !== e) begin errors++; $display("FAIL prio_seq w%0d got %0d expected %0d", w, o, e); end
        end
      end
    end
    @(posedge CLK); #1 bt_req = 1'b0;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (grant !== 2'd2) begin errors++; $display("FAIL prio_grant_au got %0d expected 2", grant); end
    checks++;
    if (both_on != 0) begin errors++; $display("FAIL prio_both_en got %0d expected 0", both_on); end
  endtask

  task automatic test_estop();
    logic ok = 1'b0;
    @(posedge CLK); #1 au_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (!busy && !d2_busy) begin ok = 1'b1; break; end
    end
    checks++;
    if (ok !== 1'b1 || grant !== 2'd3) begin errors++; $display("FAIL estop_setup_idle got busy %b grant %0d expected 0 3", busy, grant); end
    @(posedge CLK); #1 au_req = 1'b1; au_cmd = CMD_FWD; au_spd = 8'd100;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (l_speed == 8'd64) begin ok = 1'b1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL estop_reach64 got %0d expected 64", l_speed); end
    @(posedge CLK); #1 obs_estop = 1'b1;
    @(posedge CLK); #1 obs_estop = 1'b0;
    @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed} !== 21'd0) begin
      errors++; $display("FAIL estop_stop got %b expected 0", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed});
    end
    @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy} !== 5'b10101) begin
      errors++; $display("FAIL estop_resume got %b expected 10101", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy});
    end
  endtask

  task automatic test_cmd7();
    logic ok = 1'b0;
    @(posedge CLK); #1 au_cmd = 3'd7; au_spd = 8'd80;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (grant !== 2'd2) begin errors++; $display("FAIL cmd7_grant got %0d expected 2", grant); end
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!busy && !d2_busy) begin ok = 1'b1; break; end
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (ok !== 1'b1 || {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed} !== 21'd0) begin
      errors++; $display("FAIL cmd7_stop got %b expected 0", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed});
    end
  endtask

  task automatic test_clamp();
    logic [7:0] e, o;
    @(posedge CLK); #1;
    clear_sb();
    exp_q[2].push_back(8'd200); exp_q[2].push_back(8'd255);
    au_cmd = CMD_FWD; au_spd = 8'd255;
    repeat (40) @(negedge CLK);
    checks++;
    if ({d2_l_en_dir1, d2_l_en_dir2, d2_l_speed, d2_r_speed, d2_grant} !== {2'b10, 8'd255, 8'd255, 2'd2}) begin
      errors++; $display("FAIL clamp_top got %b %0d %0d g%0d expected 10 255 255 g2", {d2_l_en_dir1, d2_l_en_dir2}, d2_l_speed, d2_r_speed, d2_grant);
    end
    @(posedge CLK); #1;
    exp_q[2].push_back(8'd55); exp_q[2].push_back(8'd0);
    au_cmd = CMD_STOP;
    repeat (40) @(negedge CLK);
    checks++;
    if (d2_busy !== 1'b0) begin errors++; $display("FAIL clamp_stop_busy got %b expected 0", d2_busy); end
    while (exp_q[2].size() > 0) begin
      e = exp_q[2].pop_front();
      checks++;
      if (obs_q[2].size() == 0) begin errors++; $display("FAIL clamp_seq got none expected %0d", e); end
      else begin
        o = obs_q[2].pop_front();
        if (o !== e) begin errors++; $display("FAIL clamp_seq got %0d expected %0d", o, e); end
      end
    end
    checks++;
    if (obs_q[2].size() != 0) begin errors++; $display("FAIL clamp_seq_extra got %0d expected 0", obs_q[2].size()); end
  endtask

  task automatic test_reset_in_dead();
    logic ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(posedge CLK); #1 au_cmd = CMD_FWD; au_spd = 8'd20;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (l_speed == 8'd20) break;
    end
    @(posedge CLK); #1 au_cmd = CMD_BACK;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if ({l_en_dir1, l_en_dir2} == 2'b00 && busy) begin ok = 1'b1; break; end
    end
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rstdead_reach got timeout expected dead"); end
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy, l_speed, r_speed, grant} !== {21'd0, 2'd3}) begin
      errors++; $display("FAIL rstdead_async got %b g%0d expected 0 g3", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2, busy}, grant);
    end
    @(posedge CLK); #1 RST_N = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks++;
    if ({grant, l_en_dir1, l_en_dir2} !== {2'd2, 2'b00}) begin
      errors++; $display("FAIL rstdead_n1 got g%0d en %b expected g2 en 00", grant, {l_en_dir1, l_en_dir2});
    end
    @(negedge CLK);
    checks++;
    if ({l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2} !== 4'b0101) begin
      errors++; $display("FAIL rstdead_nodead got %b expected 0101", {l_en_dir1, l_en_dir2, r_en_dir1, r_en_dir2});
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_priority();
    test_estop();
    test_cmd7();
    test_clamp();
    test_reset_in_dead();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
